// File: rtl/halt_dump_streamer_if.sv
// Byte-wide valid/ready stream used by the halt dump streamer.
// master = byte source (the streamer), slave = byte sink.
interface halt_dump_streamer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/halt_dump_streamer.sv
// After a halt rising edge, reads the register file and the whole RAM and emits
// a framed byte stream: header, register bytes, memory bytes, 8-bit checksum.
module halt_dump_streamer #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_REGS   = 8,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halted,
  input  logic                    dump_en,
  output logic [2:0]              reg_sel,
  input  logic [DATA_WIDTH-1:0]   reg_data,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd_en,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  halt_dump_streamer_if.master    out_if,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REGS,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_MEM_OUT,
    S_SUM
  } state_e;

  localparam logic [2:0]            LAST_REG  = 3'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q,     state_d;
  logic                    halted_q,    halted_d;
  logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
  logic [2:0]              reg_sel_q,   reg_sel_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;
  logic [DATA_WIDTH-1:0]   checksum_q,  checksum_d;

  logic                    xfer;
  logic [DATA_WIDTH-1:0]   sum_next;

  assign xfer     = out_valid_q && out_if.ready;
  assign sum_next = checksum_q + out_data_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    halted_d    = halted;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    reg_sel_d   = reg_sel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    checksum_d  = checksum_q;

    unique case (state_q)
      S_IDLE: begin
        if (halted && !halted_q && dump_en) begin
          state_d     = S_HDR;
          out_data_d  = HEADER;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          checksum_d  = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          reg_sel_d   = '0;
          state_d     = S_REGS;
        end
      end
      S_REGS: begin
        // Register read data is combinational, so one load cycle per byte with valid low.
        if (!out_valid_q) begin
          out_data_d  = reg_data;
          out_valid_d = 1'b1;
        end else if (xfer) begin
          checksum_d  = sum_next;
          out_valid_d = 1'b0;
          if (reg_sel_q == LAST_REG) begin
            mem_addr_d  = '0;
            mem_rd_en_d = 1'b1;
            state_d     = S_MEM_REQ;
          end else begin
            reg_sel_d = reg_sel_q + 3'd1;
          end
        end
      end
      S_MEM_REQ: begin
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        out_data_d  = mem_rd_data;
        out_valid_d = 1'b1;
        state_d     = S_MEM_OUT;
      end
      S_MEM_OUT: begin
        if (xfer) begin
          checksum_d = sum_next;
          if (mem_addr_q == LAST_ADDR) begin
            // Checksum byte goes out straight away with the final total.
            out_data_d  = sum_next;
            out_valid_d = 1'b1;
            state_d     = S_SUM;
          end else begin
            out_valid_d = 1'b0;
            mem_addr_d  = mem_addr_q + 1'b1;
            mem_rd_en_d = 1'b1;
            state_d     = S_MEM_REQ;
          end
        end
      end
      S_SUM: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all flops clear on async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      halted_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      reg_sel_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      reg_sel_q   <= reg_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  assign out_if.data  = out_data_q;
  assign out_if.valid = out_valid_q;
  assign reg_sel      = reg_sel_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_halt_dump_streamer.sv
// Bench for halt_dump_streamer: two instances (256-byte and 16-byte RAM), a frame
// model built from the register/RAM contents, and a stream monitor.
module tb_halt_dump_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic dump_en;
  logic halted0, halted1;

  logic [7:0] regs0 [8];
  logic [7:0] regs1 [8];
  logic [7:0] ram0  [256];
  logic [7:0] ram1  [16];

  logic [2:0] reg_sel0, reg_sel1;
  logic [7:0] mem_addr0;
  logic [3:0] mem_addr1;
  logic       rd_en0, rd_en1;
  logic [7:0] rd_data0, rd_data1;
  logic       busy0, busy1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  halt_dump_streamer_if s0 ();
  halt_dump_streamer_if s1 ();

  halt_dump_streamer #(.ADDR_WIDTH(8)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .halted     (halted0),
    .dump_en    (dump_en),
    .reg_sel    (reg_sel0),
    .reg_data   (regs0[reg_sel0]),
    .mem_addr   (mem_addr0),
    .mem_rd_en  (rd_en0),
    .mem_rd_data(rd_data0),
    .out_if     (s0),
    .busy       (busy0),
    .done       (done0)
  );

  halt_dump_streamer #(.ADDR_WIDTH(4)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .halted     (halted1),
    .dump_en    (dump_en),
    .reg_sel    (reg_sel1),
    .reg_data   (regs1[reg_sel1]),
    .mem_addr   (mem_addr1),
    .mem_rd_en  (rd_en1),
    .mem_rd_data(rd_data1),
    .out_if     (s1),
    .busy       (busy1),
    .done       (done1)
  );

  // Synchronous-read RAMs: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= ram0[mem_addr0];
    if (rd_en1) rd_data1 <= ram1[mem_addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic trigger(input bit sel, input string tag);
    if (sel) halted1 = 1'b0; else halted0 = 1'b0;
    @(negedge clk);
    if (sel) halted1 = 1'b1; else halted0 = 1'b1;
    @(negedge clk);
    check({tag, " hdr valid"}, sel ? s1.valid : s0.valid, 1);
    check({tag, " hdr data"},  sel ? s1.data  : s0.data,  8'hA5);
    check({tag, " busy"},      sel ? busy1    : busy0,    1);
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, " no valid"}, s0.valid, 0);
      check({tag, " no busy"},  busy0,    0);
      @(negedge clk);
    end
  endtask

  // Expected frame from the memory image; monitor runs from the negedge after trigger.
  task automatic run_dump(input bit sel, input bit rand_ready, input bit toggle_halt,
                          input int abort_at, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [7:0] sum;
    logic       v, r, dn, bz, rd, pv, pr;
    logic [7:0] d, pd;
    int depth, idx, done_cnt, rd_cnt, cyc, tail;
    depth = sel ? 16 : 256;
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      b = sel ? regs1[i] : regs0[i];
      exp_q.push_back(b);
      sum = sum + b;
    end
    for (int i = 0; i < depth; i++) begin
      b = sel ? ram1[i] : ram0[i];
      exp_q.push_back(b);
      sum = sum + b;
    end
    exp_q.push_back(sum);

    idx = 0; done_cnt = 0; rd_cnt = 0; cyc = 0; tail = 0;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    while (cyc < 20000 && tail < 4) begin
      v  = sel ? s1.valid : s0.valid;
      d  = sel ? s1.data  : s0.data;
      dn = sel ? done1    : done0;
      bz = sel ? busy1    : busy0;
      rd = sel ? rd_en1   : rd_en0;
      if (pv && !pr) begin
        check({tag, " stall valid"}, v, 1);
        check({tag, " stall data"},  d, pd);
      end
      if (dn) done_cnt++;
      if (rd) rd_cnt++;
      if (done_cnt == 0) check({tag, " busy during dump"}, bz, 1);
      if (abort_at >= 0 && idx == abort_at && v) break;
      if (toggle_halt && cyc == 50) halted0 = 1'b0;
      if (toggle_halt && cyc == 52) halted0 = 1'b1;
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) s1.ready = r; else s0.ready = r;
      if (v && r) begin
        check({tag, " no overrun"}, idx < exp_q.size(), 1);
        if (idx < exp_q.size()) check($sformatf("%s byte %0d", tag, idx), d, exp_q[idx]);
        idx++;
      end
      pv = v; pr = r; pd = d;
      if (done_cnt > 0) tail++;
      cyc++;
      @(negedge clk);
    end
    if (sel) s1.ready = 1'b1; else s0.ready = 1'b1;
    if (abort_at < 0) begin
      check({tag, " byte count"}, idx, exp_q.size());
      check({tag, " done pulses"}, done_cnt, 1);
      check({tag, " rd strobes"}, rd_cnt, depth);
      check({tag, " busy after"}, sel ? busy1 : busy0, 0);
      check({tag, " valid after"}, sel ? s1.valid : s0.valid, 0);
    end
  endtask

  initial begin
    reset = 1'b0; dump_en = 1'b1; halted0 = 1'b0; halted1 = 1'b0;
    s0.ready = 1'b1; s1.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin regs0[i] = 8'(i + 1); regs1[i] = 8'hFF; end
    for (int i = 0; i < 256; i++) ram0[i] = 8'(i);
    for (int i = 0; i < 16; i++) ram1[i] = 8'hFF;

    #12;
    check("rst valid", s0.valid, 0);
    check("rst data", s0.data, 0);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst rd_en", rd_en0, 0);
    check("rst addr", mem_addr0, 0);
    check("rst reg_sel", reg_sel0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Incrementing image, sink always ready.
    trigger(0, "t1");
    run_dump(0, 0, 0, -1, "t1");

    // Same image, random backpressure.
    trigger(0, "t2");
    run_dump(0, 1, 0, -1, "t2");

    // Random image, backpressure, halted bounces mid-dump.
    for (int i = 0; i < 8; i++) regs0[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram0[i] = 8'($urandom);
    trigger(0, "t3");
    run_dump(0, 1, 1, -1, "t3");
    quiet(20, "t3 tail");

    // dump_en low at the edge, then high with halted held: nothing starts.
    halted0 = 1'b0; dump_en = 1'b0;
    @(negedge clk); @(negedge clk);
    halted0 = 1'b1;
    quiet(10, "t4 disarmed");
    dump_en = 1'b1;
    quiet(10, "t4 no edge");

    // Reset while memory byte 0x40 is on the stream.
    for (int i = 0; i < 8; i++) regs0[i] = 8'(i + 1);
    for (int i = 0; i < 256; i++) ram0[i] = 8'(i);
    trigger(0, "t5");
    run_dump(0, 0, 0, 9 + 8'h40, "t5");
    check("t5 pre-abort data", s0.data, 8'h40);
    reset = 1'b0;
    #1;
    check("t5 abort valid", s0.valid, 0);
    check("t5 abort busy", busy0, 0);
    check("t5 abort rd_en", rd_en0, 0);
    check("t5 abort data", s0.data, 0);
    check("t5 abort done", done0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5 restart valid", s0.valid, 1);
    check("t5 restart data", s0.data, 8'hA5);
    run_dump(0, 0, 0, -1, "t5 restart");

    // Small-RAM instance, everything 0xFF.
    trigger(1, "t6");
    run_dump(1, 1, 0, -1, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/halt_dump_streamer.md
Name: halt_dump_streamer

Overview:
- Reads back machine state after the CPU halts: the inverse of preloading RAM and inspecting registers at halt.
- On a halt rising edge, sequentially reads the CPU register file and the whole RAM, then streams them as a framed byte stream on a valid/ready output: header, register bytes, memory bytes, checksum.
- Sits beside the machine top level and taps the register-file debug read port and a RAM read port. Feeds a UART transmitter or a bench sink.

Parameters:
- ADDR_WIDTH, 8, RAM address width; RAM depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 8, RAM/register data width; fixed at 8 for this version.
- NUM_REGS, 8, registers dumped (A,B,C,D,E,F,G,Temp); reg_sel index 0..NUM_REGS-1.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- halted  in  1  CPU halted flag, synchronous to clk.
- dump_en  in  1  arms the block; sampled only at trigger.
- reg_sel  out  3  register-file debug read select.
- reg_data  in  8  combinational read data for reg_sel, same cycle.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_data  in  8  RAM data, valid exactly one cycle after mem_rd_en.
- out_data  out  8  stream byte.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  sink ready; transfer on the cycle where out_valid=1 and out_ready=1.
- busy  out  1  high from trigger until done.
- done  out  1  one-cycle pulse after the checksum byte transfers.

Behaviour:
- Reset (reset=0, async): state=IDLE, halted_q=0, out_valid=0, out_data=0, mem_rd_en=0, mem_addr=0, reg_sel=0, busy=0, done=0, checksum=0.
- Trigger: halted=1 and halted_q=0 at a posedge, with dump_en=1 and state=IDLE.
  - halted_q captures halted every cycle.
  - At the trigger edge: state goes to HDR, out_data=HEADER, out_valid=1, busy=1, checksum=0. Latency is one edge.
  - halted already high at reset release counts as a rising edge.
- Trigger is ignored while busy. If halted falls mid-dump, the dump still completes.
- States: IDLE -> HDR -> REGS -> MEM_REQ -> MEM_WAIT -> MEM_OUT -> (MEM_REQ | SUM) -> IDLE.
- HDR: on transfer, reg_sel=0, go to REGS.
- REGS:
  - out_data is registered from reg_data with out_valid=1.
  - On each transfer: checksum += byte; if reg_sel==NUM_REGS-1 then mem_addr=0 and go to MEM_REQ, else reg_sel++.
  - The byte is loaded one cycle after entering REGS or after the previous transfer; out_valid=0 during that load cycle.
- MEM_REQ: mem_rd_en=1 for exactly one cycle; out_valid=0; go to MEM_WAIT.
- MEM_WAIT: capture mem_rd_data into out_data, set out_valid=1, go to MEM_OUT.
- MEM_OUT, on transfer: checksum += byte.
  - If mem_addr == 2^ADDR_WIDTH-1, go to SUM; mem_addr does not wrap.
  - Otherwise mem_addr++ and go to MEM_REQ.
- SUM: out_data = checksum (mod 256) with out_valid=1. On transfer: out_valid=0, busy=0, done=1 for one cycle, go to IDLE.
- Checksum is the 8-bit wrap-around sum of the register and memory bytes; the header is excluded.
- Stream rule: while out_valid=1 and out_ready=0, out_data and out_valid hold stable. out_valid never drops without a transfer.
- Frame length is 1 + NUM_REGS + 2^ADDR_WIDTH + 1 bytes (266 with defaults).
- The block never writes RAM or registers. mem_addr and reg_sel hold their last value in IDLE.
- Reset mid-dump aborts immediately to IDLE with all outputs at reset values; no done pulse.

Test Plan:
- Regs A..Temp = 01..08, RAM[i]=i, out_ready=1, pulse halted -> out_valid high one edge after trigger. Stream is A5, 01..08, 00..FF, checksum 8'h A4 (36 + 32640 mod 256 = 0x24+0x80). done pulses once; 266 bytes total.
- Same setup, out_ready toggling pseudo-randomly -> identical byte sequence, out_data stable whenever stalled, no duplicated or dropped bytes.
- dump_en=0 when halted rises -> busy stays 0, no out_valid. Then dump_en=1 with halted held high -> no dump (no new edge).
- halted toggled 1-0-1 mid-dump -> single frame only; busy stays 1 until done; no second frame.
- reset driven low while streaming memory byte 0x40 -> out_valid, busy, mem_rd_en all 0 immediately. After release with halted still high, a fresh frame starts with A5.
- RAM all FF, regs all FF, ADDR_WIDTH=4 -> frame A5, 8×FF, 16×FF, checksum E8 (24×FF mod 256); mem_rd_en asserted exactly 16 times.
